// File: rtl/x86_sram_bridge.sv
// x86_sram_bridge: x86cpu byte bus responder serving each byte access from 16-bit async SRAM.
// Optional last-word read cache enabled by defining X86_SRAM_LAST_WORD_CACHE_EN.
module x86_sram_bridge #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_o_data,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_i_data,
  output logic              cpu_locked,
  output logic [ADDR_W-2:0] sram_addr,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("x86_sram_bridge: WAIT_STATES must be in 1..15");
  end

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_req_wr;
  logic       r_req_lane;
  logic [7:0] w_rd_byte;
  logic       w_hit;
  logic [7:0] w_hit_byte;

  assign w_rd_byte = r_req_lane ? sram_dq_i[15:8] : sram_dq_i[7:0];

`ifdef X86_SRAM_LAST_WORD_CACHE_EN
  logic [15:0]       r_cache_word;
  logic [ADDR_W-2:0] r_cache_tag;
  logic              r_cache_valid;
  logic              w_tag_match;

  assign w_tag_match = r_cache_valid && (r_cache_tag == cpu_address[ADDR_W-1:1]);
  assign w_hit       = w_tag_match && !cpu_wr;
  assign w_hit_byte  = cpu_address[0] ? r_cache_word[15:8] : r_cache_word[7:0];

  // writes keep the cached word coherent; reads refill it as the SRAM word is captured
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cache_valid <= 1'b0;
      r_cache_tag   <= '0;
      r_cache_word  <= '0;
    end else if (r_state == S_IDLE && cpu_wr && w_tag_match) begin
      if (cpu_address[0]) r_cache_word[15:8] <= cpu_o_data;
      else r_cache_word[7:0] <= cpu_o_data;
    end else if (r_state == S_ACCESS && r_cnt == 4'd0 && !r_req_wr) begin
      r_cache_valid <= 1'b1;
      r_cache_tag   <= sram_addr;
      r_cache_word  <= sram_dq_i;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_byte = 8'h00;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_req_wr   <= 1'b0;
      r_req_lane <= 1'b0;
      cpu_locked <= 1'b0;
      cpu_i_data <= 8'h00;
      sram_addr  <= '0;
      sram_dq_o  <= 16'h0000;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_wr   <= cpu_wr;
          r_req_lane <= cpu_address[0];
          sram_addr  <= cpu_address[ADDR_W-1:1];
          sram_dq_o  <= {cpu_o_data, cpu_o_data};
          r_cnt      <= 4'(WAIT_STATES);
          if (w_hit) begin
            r_state    <= S_DONE;
            cpu_locked <= 1'b1;
            cpu_i_data <= w_hit_byte;
          end else begin
            r_state    <= S_ACCESS;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= cpu_wr;
            sram_we_n  <= ~cpu_wr;
            sram_dq_oe <= cpu_wr;
            sram_ub_n  <= ~cpu_address[0];
            sram_lb_n  <= cpu_address[0];
          end
        end
        S_ACCESS: begin
          // we_n rises one clock before the end so data is held past the write pulse
          if (r_cnt == 4'd1) sram_we_n <= 1'b1;
          if (r_cnt == 4'd0) begin
            r_state    <= S_DONE;
            cpu_locked <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!r_req_wr) cpu_i_data <= w_rd_byte;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          cpu_locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_x86_sram_bridge.sv
// tb_x86_sram_bridge: directed-vector bench for x86_sram_bridge with a behavioural async SRAM.
module tb_x86_sram_bridge;
  localparam int W    = 2;
  localparam int MISS = W + 3;
`ifdef X86_SRAM_LAST_WORD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int HIT = CACHE ? 2 : MISS;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_o_data = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_i_data;
  logic        cpu_locked;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [15:0] mem [0:(1<<19)-1];

  int n_vec = 0;
  int n_err = 0;
  int n_clk, ce_low, oe_low, we_low, dqoe_cnt, overlap;
  logic [18:0] addr_cap;
  logic [15:0] dqo_cap;
  logic [7:0]  rd;
  logic [4:0]  done_strb;
  logic        ub_cap, lb_cap, last_we, last_dqoe, locked_next, done_oe, got;

  x86_sram_bridge #(.WAIT_STATES(W), .ADDR_W(20)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_o_data(cpu_o_data),
    .cpu_wr(cpu_wr), .cpu_i_data(cpu_i_data), .cpu_locked(cpu_locked), .sram_addr(sram_addr),
    .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #40 clock = ~clock;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(posedge clock) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[sram_addr][7:0] <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
    end
  end

  // Called at the negedge of an IDLE clock; returns at the negedge of the following IDLE clock.
  task automatic run_access(input logic [19:0] a, input logic wr, input logic [7:0] d, input logic scramble);
    cpu_address = a; cpu_wr = wr; cpu_o_data = d;
    n_clk = 1; ce_low = 0; oe_low = 0; we_low = 0; dqoe_cnt = 0; overlap = 0; got = 1'b0;
    addr_cap = '1; dqo_cap = '0; ub_cap = 1'b1; lb_cap = 1'b1; last_we = 1'b0; last_dqoe = 1'b0;
    rd = 8'hxx; done_strb = 5'b0; done_oe = 1'b1;
    while (!got && n_clk < 40) begin
      @(negedge clock);
      n_clk++;
      if (scramble) begin cpu_address = ~a; cpu_wr = ~wr; cpu_o_data = ~d; end
      if (!sram_ce_n) begin
        ce_low++; addr_cap = sram_addr; ub_cap = sram_ub_n; lb_cap = sram_lb_n;
        dqo_cap = sram_dq_o; last_we = sram_we_n; last_dqoe = sram_dq_oe;
      end
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      if (sram_dq_oe) dqoe_cnt++;
      if (!sram_oe_n && sram_dq_oe) overlap++;
      if (cpu_locked) begin
        got = 1'b1; rd = cpu_i_data; done_oe = sram_dq_oe;
        done_strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
      end
    end
    if (!got) n_clk = 0;
    @(negedge clock);
    locked_next = cpu_locked;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin n_err++; $display("FAIL reset_strobes got %b want 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    n_vec++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL reset_dq_oe got %b want 0", sram_dq_oe); end
    n_vec++; if (cpu_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", cpu_locked); end
    n_vec++; if (cpu_i_data !== 8'h00) begin n_err++; $display("FAIL reset_i_data got %h want 00", cpu_i_data); end
    n_vec++; if (sram_addr !== 19'h0) begin n_err++; $display("FAIL reset_sram_addr got %h want 0", sram_addr); end
    reset_n = 1'b1;
    run_access(20'h00010, 1'b0, 8'h00, 1'b0);
    n_vec++; if (n_clk !== MISS) begin n_err++; $display("FAIL first_lock_latency got %0d want %0d", n_clk, MISS); end
    n_vec++; if (rd !== 8'h5A) begin n_err++; $display("FAIL first_read got %h want 5a", rd); end
  endtask

  task automatic test_read;
    run_access(20'h01234, 1'b0, 8'h00, 1'b0);
    n_vec++; if (n_clk !== MISS) begin n_err++; $display("FAIL rd_lo_latency got %0d want %0d", n_clk, MISS); end
    n_vec++; if (addr_cap !== 19'h0091A) begin n_err++; $display("FAIL rd_lo_addr got %h want 0091a", addr_cap); end
    n_vec++; if ({ub_cap, lb_cap} !== 2'b10) begin n_err++; $display("FAIL rd_lo_lanes got %b want 10", {ub_cap, lb_cap}); end
    n_vec++; if (oe_low !== W + 1) begin n_err++; $display("FAIL rd_lo_oe_clocks got %0d want %0d", oe_low, W + 1); end
    n_vec++; if (we_low !== 0 || dqoe_cnt !== 0) begin n_err++; $display("FAIL rd_lo_no_drive got we=%0d oe=%0d want 0 0", we_low, dqoe_cnt); end
    n_vec++; if (rd !== 8'hEF) begin n_err++; $display("FAIL rd_lo_data got %h want ef", rd); end
    n_vec++; if (done_strb !== 5'b11111 || done_oe !== 1'b0) begin n_err++; $display("FAIL rd_done_idle got %b/%b want 11111/0", done_strb, done_oe); end
    n_vec++; if (locked_next !== 1'b0) begin n_err++; $display("FAIL rd_locked_one_clock got %b want 0", locked_next); end
    run_access(20'h01235, 1'b0, 8'h00, 1'b0);
    n_vec++; if (n_clk !== HIT) begin n_err++; $display("FAIL rd_hi_latency got %0d want %0d", n_clk, HIT); end
    n_vec++; if (ub_cap !== CACHE) begin n_err++; $display("FAIL rd_hi_ub got %b want %b", ub_cap, CACHE); end
    n_vec++; if (rd !== 8'hBE) begin n_err++; $display("FAIL rd_hi_data got %h want be", rd); end
  endtask

  task automatic test_write;
    run_access(20'hFFFFF, 1'b1, 8'h5A, 1'b0);
    n_vec++; if (n_clk !== MISS) begin n_err++; $display("FAIL wr_latency got %0d want %0d", n_clk, MISS); end
    n_vec++; if (addr_cap !== 19'h7FFFF) begin n_err++; $display("FAIL wr_addr_wrap got %h want 7ffff", addr_cap); end
    n_vec++; if ({ub_cap, lb_cap} !== 2'b01) begin n_err++; $display("FAIL wr_lanes got %b want 01", {ub_cap, lb_cap}); end
    n_vec++; if (dqo_cap !== 16'h5A5A) begin n_err++; $display("FAIL wr_dq_o got %h want 5a5a", dqo_cap); end
    n_vec++; if (we_low !== W) begin n_err++; $display("FAIL wr_we_clocks got %0d want %0d", we_low, W); end
    n_vec++; if ({last_we, last_dqoe} !== 2'b11) begin n_err++; $display("FAIL wr_hold got %b want 11", {last_we, last_dqoe}); end
    n_vec++; if (dqoe_cnt !== W + 1 || oe_low !== 0 || overlap !== 0) begin n_err++; $display("FAIL wr_turnaround got dqoe=%0d oe=%0d ov=%0d want %0d 0 0", dqoe_cnt, oe_low, overlap, W + 1); end
    n_vec++; if (rd !== 8'hBE) begin n_err++; $display("FAIL wr_i_data_held got %h want be", rd); end
    n_vec++; if (locked_next !== 1'b0) begin n_err++; $display("FAIL wr_locked_one_clock got %b want 0", locked_next); end
    run_access(20'hFFFFF, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'h5A || n_clk !== MISS) begin n_err++; $display("FAIL wr_readback got %h/%0d want 5a/%0d", rd, n_clk, MISS); end
    run_access(20'hFFFFE, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'h11 || n_clk !== HIT) begin n_err++; $display("FAIL wr_other_lane got %h/%0d want 11/%0d", rd, n_clk, HIT); end
  endtask

  task automatic test_lanes;
    run_access(20'h00100, 1'b1, 8'h33, 1'b0);
    n_vec++; if (mem[19'h00080] !== 16'h1233) begin n_err++; $display("FAIL lane_lo_write got %h want 1233", mem[19'h00080]); end
    run_access(20'h00101, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'h12 || n_clk !== MISS) begin n_err++; $display("FAIL lane_hi_read got %h/%0d want 12/%0d", rd, n_clk, MISS); end
    run_access(20'h00100, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'h33 || n_clk !== HIT) begin n_err++; $display("FAIL lane_lo_read got %h/%0d want 33/%0d", rd, n_clk, HIT); end
  endtask

  task automatic test_input_ignore;
    run_access(20'h01234, 1'b0, 8'h00, 1'b1);
    n_vec++; if (addr_cap !== 19'h0091A || we_low !== 0) begin n_err++; $display("FAIL ignore_inputs got addr=%h we=%0d want 0091a 0", addr_cap, we_low); end
    n_vec++; if (rd !== 8'hEF || n_clk !== MISS) begin n_err++; $display("FAIL ignore_data got %h/%0d want ef/%0d", rd, n_clk, MISS); end
  endtask

  task automatic test_reset_mid;
    cpu_address = 20'h00200; cpu_wr = 1'b1; cpu_o_data = 8'h99;
    repeat (2) @(negedge clock);
    n_vec++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL mid_we_active got %b want 0", sram_we_n); end
    reset_n = 1'b0;
    @(negedge clock);
    n_vec++; if ({sram_we_n, sram_ce_n, sram_dq_oe} !== 3'b110) begin n_err++; $display("FAIL mid_reset_strobes got %b want 110", {sram_we_n, sram_ce_n, sram_dq_oe}); end
    n_vec++; if (cpu_locked !== 1'b0 || cpu_i_data !== 8'h00) begin n_err++; $display("FAIL mid_reset_cpu got %b/%h want 0/00", cpu_locked, cpu_i_data); end
    @(negedge clock);
    n_vec++; if (cpu_locked !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_lock got %b want 0", cpu_locked); end
    reset_n = 1'b1;
    run_access(20'h01235, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'hBE || n_clk !== MISS) begin n_err++; $display("FAIL mid_reset_recover got %h/%0d want be/%0d", rd, n_clk, MISS); end
  endtask

`ifdef X86_SRAM_LAST_WORD_CACHE_EN
  task automatic test_cache;
    run_access(20'h00010, 1'b0, 8'h00, 1'b0);
    run_access(20'h01234, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'hEF || n_clk !== MISS) begin n_err++; $display("FAIL cache_fill got %h/%0d want ef/%0d", rd, n_clk, MISS); end
    run_access(20'h01235, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'hBE || n_clk !== 2 || ce_low !== 0) begin n_err++; $display("FAIL cache_hit got %h/%0d/ce%0d want be/2/ce0", rd, n_clk, ce_low); end
    run_access(20'h01235, 1'b1, 8'h77, 1'b0);
    n_vec++; if (mem[19'h0091A] !== 16'h77EF || n_clk !== MISS) begin n_err++; $display("FAIL cache_write got %h/%0d want 77ef/%0d", mem[19'h0091A], n_clk, MISS); end
    run_access(20'h01235, 1'b0, 8'h00, 1'b0);
    n_vec++; if (rd !== 8'h77 || n_clk !== 2 || ce_low !== 0) begin n_err++; $display("FAIL cache_update got %h/%0d/ce%0d want 77/2/ce0", rd, n_clk, ce_low); end
  endtask
`endif

  initial begin
    mem[19'h00008] = 16'hA55A;
    mem[19'h0091A] = 16'hBEEF;
    mem[19'h7FFFF] = 16'h1111;
    mem[19'h00080] = 16'h1200;
    mem[19'h00100] = 16'h0000;
    test_reset();
    test_read();
    test_write();
    test_lanes();
    test_input_ignore();
    test_reset_mid();
`ifdef X86_SRAM_LAST_WORD_CACHE_EN
    test_cache();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
